// File: rtl/stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : stream_decoder
// Description : Memory-to-memory decoder for the chained rotate/XOR word
//               encoding. On an accepted start it reads the 2**LEN_W encoded
//               words of block file_index, decodes each one as
//               d(i) = rotr(e(i), i mod WORD_W) ^ c(i-1) with c(i) = e(i) and
//               c(-1) = KEY, writes the plaintext to the destination port and
//               raises finish.
//               Optional feature macro: STREAM_DECODER_PARITY_EN enables the
//               even-parity check on rd_data[WORD_W] (sticky parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
module stream_decoder #(
    parameter int                WORD_W = 32,
    parameter int                LEN_W  = 4,
    parameter logic [WORD_W-1:0] KEY    = {WORD_W{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [9:0]            file_index,
    output logic                  finish,
    output logic                  rd_en,
    output logic [10+LEN_W-1:0]   rd_addr,
    input  logic [WORD_W:0]       rd_data,
    output logic                  wr_en,
    output logic [10+LEN_W-1:0]   wr_addr,
    output logic [WORD_W-1:0]     wr_data,
    output logic                  parity_err
);

    localparam int       c_SH_W     = $clog2(WORD_W);
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD   = 3'd1;
    localparam logic [2:0] c_ST_WT   = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic                w_accept;
    logic [9:0]          r_fidx;
    logic [LEN_W-1:0]    r_idx;
    logic [WORD_W-1:0]   r_chain;
    logic [WORD_W-1:0]   r_wr_data;
    logic [10+LEN_W-1:0] r_wr_addr;
    logic                r_parity_err;
    logic [WORD_W-1:0]   w_enc;
    logic [c_SH_W-1:0]   w_rot_amt;
    logic [WORD_W-1:0]   w_rotr;
    logic                w_last;
    logic                w_parity_bad;

    assign w_enc  = rd_data[WORD_W-1:0];
    assign w_last = &r_idx;

    // Rotation amount is i mod WORD_W: the low log2(WORD_W) bits of the index.
    generate
        if (LEN_W >= c_SH_W) begin : g_rot_trunc
            assign w_rot_amt = r_idx[c_SH_W-1:0];
        end else begin : g_rot_ext
            assign w_rot_amt = {{(c_SH_W-LEN_W){1'b0}}, r_idx};
        end
    endgenerate

    // A shift by the full width yields zero, so amount 0 returns w_enc as is.
    assign w_rotr = (w_enc >> w_rot_amt) | (w_enc << (WORD_W - int'(w_rot_amt)));

`ifdef STREAM_DECODER_PARITY_EN
    assign w_parity_bad = rd_data[WORD_W] ^ (^w_enc);
`else
    // Parity bit is ignored; keeping it on a named sink documents that.
    logic w_unused_parity;
    assign w_unused_parity = rd_data[WORD_W];
    assign w_parity_bad    = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        finish       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_RD;
                    w_accept     = 1'b1;
                end
            end
            c_ST_RD: begin
                rd_en        = 1'b1;
                w_next_state = c_ST_WT;
            end
            c_ST_WT: begin
                w_next_state = c_ST_WR;
            end
            c_ST_WR: begin
                wr_en        = 1'b1;
                w_next_state = w_last ? c_ST_DONE : c_ST_RD;
            end
            c_ST_DONE: begin
                finish = 1'b1;
                if (start) begin
                    w_next_state = c_ST_RD;
                    w_accept     = 1'b1;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Datapath: the word is decoded as it is captured at the end of WT so the
    // write port carries registered data/address for the whole WR cycle and
    // holds them afterwards; the chain value advances at the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fidx       <= 10'd0;
            r_idx        <= {LEN_W{1'b0}};
            r_chain      <= {WORD_W{1'b0}};
            r_wr_data    <= {WORD_W{1'b0}};
            r_wr_addr    <= {(10+LEN_W){1'b0}};
            r_parity_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fidx       <= file_index;
                r_idx        <= {LEN_W{1'b0}};
                r_chain      <= KEY;
                r_parity_err <= 1'b0;
            end
            if (r_state == c_ST_WT) begin
                r_wr_data <= w_rotr ^ r_chain;
                r_wr_addr <= {r_fidx, r_idx};
                r_chain   <= w_enc;
                if (w_parity_bad) r_parity_err <= 1'b1;
            end
            if (r_state == c_ST_WR) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

    assign rd_addr    = {r_fidx, r_idx};
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_decoder
// Description : Self-checking bench for stream_decoder (WORD_W=32, LEN_W=2,
//               KEY=32'hA5A5A5A5). A memory model answers reads one cycle
//               after rd_en; a reference model decodes blocks straight from
//               the chaining rule with bit-by-bit rotation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_decoder;

    localparam int          WORD_W  = 32;
    localparam int          LEN_W   = 2;
    localparam logic [31:0] KEY     = 32'hA5A5A5A5;
    localparam int          NW      = 1 << LEN_W;
    localparam int          AW      = 10 + LEN_W;
    localparam int          FIN_CYC = 3 * NW + 1;
`ifdef STREAM_DECODER_PARITY_EN
    localparam bit          PAR_ON  = 1'b1;
`else
    localparam bit          PAR_ON  = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          start;
    logic [9:0]    file_index;
    logic          finish;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [32:0]   rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          parity_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0]   src [0:(1<<AW)-1];
    logic [31:0]   last_wd[$];

    stream_decoder #(.WORD_W(WORD_W), .LEN_W(LEN_W), .KEY(KEY)) dut (
        .clk(clk), .rst(rst), .start(start), .file_index(file_index),
        .finish(finish), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source memory: data appears exactly one cycle after rd_en, garbage otherwise.
    always @(posedge clk)
        rd_data <= rd_en ? src[rd_addr] : {1'($urandom), 32'($urandom)};

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rot_right(logic [31:0] v, int n);
        for (int k = 0; k < n; k++) v = {v[0], v[31:1]};
        return v;
    endfunction

    function automatic logic [31:0] model_word(int fi, int j);
        logic [31:0] c, e, d;
        c = KEY;
        d = '0;
        for (int k = 0; k <= j; k++) begin
            e = src[fi*NW + k][31:0];
            d = rot_right(e, k % WORD_W) ^ c;
            c = e;
        end
        return d;
    endfunction

    task automatic fill_block(input int fi, input int err_word);
        logic [31:0] w;
        for (int j = 0; j < NW; j++) begin
            w = $urandom;
            src[fi*NW + j] = {(^w) ^ (j == err_word), w};
        end
    endtask

    // One run: start edge is cycle 0; each loop pass observes cycle r at its
    // falling edge, then sets inputs sampled by the edge ending cycle r.
    task automatic run_block(input int fi, input int hold, input bit busy,
                             input int err_word, input int rst_at);
        logic [AW-1:0] qa[$];
        int            qc[$];
        int            fin_r;
        int            n_exp;
        bit            active;
        logic [AW-1:0] ea;
        logic [9:0]    fi10;
        logic [LEN_W-1:0] jj;
        fi10 = fi[9:0];
        last_wd.delete();
        @(negedge clk);
        file_index = fi10;
        start      = 1'b1;
        @(posedge clk);
        fin_r = -1;
        for (int r = 1; r <= 60; r++) begin
            @(negedge clk);
            active = (rst_at == 0 || r <= rst_at);
            if (wr_en) begin
                qa.push_back(wr_addr);
                last_wd.push_back(wr_data);
                qc.push_back(r);
            end
            chk($sformatf("rd_en c%0d", r), rd_en, active && r <= 3*NW && (r % 3) == 1);
            chk($sformatf("wr_en c%0d", r), wr_en, active && r <= 3*NW && (r % 3) == 0);
            if (active && r <= 3*NW && (r % 3) == 1) begin
                jj = LEN_W'((r - 1) / 3);
                chk($sformatf("rd_addr c%0d", r), rd_addr, {fi10, jj});
            end
            chk($sformatf("parity_err c%0d", r), parity_err,
                active && PAR_ON && err_word >= 0 && r >= 3 + 3*err_word);
            if (finish && fin_r < 0) fin_r = r;
            start = (r < hold) || (busy && r == 4);
            if (busy && r == 4) file_index = 10'd5;
            if (rst_at > 0 && r == rst_at)     rst = 1'b0;
            if (rst_at > 0 && r == rst_at + 2) rst = 1'b1;
            if (rst_at == 0 && fin_r >= 0) break;
            if (rst_at > 0 && r >= rst_at + 12) break;
        end
        start = 1'b0;
        if (rst_at == 0) begin
            chk($sformatf("finish_cycle blk%0d", fi), fin_r, FIN_CYC);
            n_exp = NW;
        end else begin
            chk($sformatf("finish_after_abort blk%0d", fi), fin_r, -1);
            n_exp = 0;
            for (int j = 0; j < NW; j++) if (3 + 3*j <= rst_at) n_exp++;
        end
        chk($sformatf("wr_count blk%0d", fi), qa.size(), n_exp);
        for (int j = 0; j < n_exp && j < qa.size(); j++) begin
            jj = j[LEN_W-1:0];
            ea = {fi10, jj};
            chk($sformatf("wr_addr blk%0d w%0d", fi, j), qa[j], ea);
            chk($sformatf("wr_data blk%0d w%0d", fi, j), last_wd[j], model_word(fi, j));
            chk($sformatf("wr_cycle blk%0d w%0d", fi, j), qc[j], 3 + 3*j);
        end
        if (rst_at == 0) begin
            jj = LEN_W'(NW - 1);
            chk($sformatf("wr_data_hold blk%0d", fi), wr_data, model_word(fi, NW - 1));
            chk($sformatf("wr_addr_hold blk%0d", fi), wr_addr, {fi10, jj});
        end
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) src[a] = {1'($urandom), 32'($urandom)};
        rst        = 1'b0;
        start      = 1'b1;
        file_index = 10'd3;

        // Reset held with start asserted: every output stays zero.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("reset_outputs c%0d", k),
                {finish, rd_en, rd_addr, wr_en, wr_addr, wr_data, parity_err}, 64'd0);
        end
        rst   = 1'b1;
        start = 1'b0;

        // Basic decode with the directed block.
        src[12] = {1'b1, 32'h1};
        src[13] = {1'b1, 32'h2};
        src[14] = {1'b0, 32'h0};
        src[15] = {1'b1, 32'h8};
        run_block(3, 1, 1'b0, -1, 0);
        chk("basic_w0", last_wd.size() > 0 ? last_wd[0] : 32'hx, 32'hA5A5A5A4);
        chk("basic_w1", last_wd.size() > 1 ? last_wd[1] : 32'hx, 32'h0);
        chk("basic_w2", last_wd.size() > 2 ? last_wd[2] : 32'hx, 32'h2);
        chk("basic_w3", last_wd.size() > 3 ? last_wd[3] : 32'hx, 32'h1);

        // Start pulse for block 5 while busy must not disturb block 3.
        fill_block(5, -1);
        run_block(3, 1, 1'b1, -1, 0);

        // Back-to-back blocks, start held three cycles each.
        for (int fi = 0; fi < 8; fi++) fill_block(fi, -1);
        for (int fi = 0; fi < 8; fi++) run_block(fi, 3, 1'b0, -1, 0);

        // Reset mid-run at cycle 6, then a clean run of the same block.
        fill_block(4, -1);
        run_block(4, 1, 1'b0, -1, 6);
        run_block(4, 1, 1'b0, -1, 0);

        // Bad parity on word 2, then a clean block clears the flag.
        fill_block(9, 2);
        run_block(9, 1, 1'b0, 2, 0);
        fill_block(10, -1);
        run_block(10, 1, 1'b0, -1, 0);

        // Highest block number: index wrap must not spill into file_index.
        fill_block(1023, -1);
        run_block(1023, 1, 1'b0, -1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_decoder.md
# stream_decoder

Memory-to-memory decoder that inverts the team's chained rotate/XOR word encoding. On a `start` handshake it reads the encoded block selected by `file_index` from a source memory port. It decodes each word in order, writes the plaintext words to a destination memory port, and raises `finish`. It is the receive-side counterpart to the encoder and shares its `start`/`finish`/`file_index` control interface, so one bench drives both.

## Interface
- `WORD_W`, 32: data word width; must be a power of 2.
- `LEN_W`, 4: words per block = 2**LEN_W.
- `KEY`, 32'h0: initial chaining value c(-1); WORD_W bits.

- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: request decode of block `file_index`; sampled only when idle/done.
- `file_index`  in  10: block number; sampled with `start`.
- `finish`  out  1: block decoded; level, held until next accepted `start`.
- `rd_en`  out  1: source read strobe.
- `rd_addr`  out  10+LEN_W: `{file_index, word_idx}`.
- `rd_data`  in  WORD_W+1: bit WORD_W = even parity over bits WORD_W-1:0; valid exactly 1 cycle after `rd_en`.
- `wr_en`  out  1: destination write strobe.
- `wr_addr`  out  10+LEN_W: `{file_index, word_idx}`.
- `wr_data`  out  WORD_W: decoded word.
- `parity_err`  out  1: sticky parity-mismatch flag for current block.

## Operation
- Decode rule for word i with encoded word e(i):
  - d(i) = rotr(e(i), i mod WORD_W) XOR c(i-1).
  - c(i) = e(i); c(-1) = KEY.
  - i counts 0..2**LEN_W-1; rotation amount is the low log2(WORD_W) bits of i.
- FSM states:
  - IDLE: no block decoded since reset.
  - RD: `rd_en`=1, `rd_addr` = current word.
  - WT: capture `rd_data`.
  - WR: `wr_en`=1; update c; increment i.
  - DONE: `finish`=1.
- Transitions:
  - IDLE/DONE --start--> RD: latch `file_index`; i=0; c=KEY; `finish`=0; `parity_err`=0.
  - RD→WT→WR unconditionally.
  - WR→RD while i≠last; WR→DONE on the last word.
- `start` is ignored in RD/WT/WR, with no effect on the run in progress.
- `start` held high in DONE immediately begins a new run.
- `rd_en` and `wr_en` are never high in the same cycle.
- Each address is written exactly once per run.

## Timing
- Reset (`rst`=0 at a clock edge) puts the FSM in IDLE. All outputs are 0: `finish`, `rd_en`, `rd_addr`, `wr_en`, `wr_addr`, `wr_data`, `parity_err`.
- `rst` asserted mid-run aborts the run: no further `wr_en` from the next edge, and `finish` stays 0.
- Count cycles from the edge that samples `start` as cycle 0.
- For word i:
  - `rd_en` is high in cycle 1+3i.
  - `rd_data` is captured at the end of cycle 2+3i.
  - `wr_en` is high in cycle 3+3i.
- `finish` rises in cycle 3·2**LEN_W + 1; total latency = 3·2**LEN_W + 1 cycles.
- `wr_data`/`wr_addr` hold their last values outside WR.
- At the wrap boundary, i reaching all-ones is the last word; there is no overflow into `file_index` bits.

## Configuration
- `STREAM_DECODER_PARITY_EN` defined:
  - In WT, a mismatch between `rd_data[WORD_W]` and the XOR of `rd_data[WORD_W-1:0]` sets `parity_err`.
  - `parity_err` stays set until the next accepted `start`.
  - Decoding and writes proceed unchanged.
- Macro undefined: no parity logic; `parity_err` is tied 0; bit WORD_W of `rd_data` is ignored.

## Test plan
All scenarios use WORD_W=32, LEN_W=2, KEY=32'hA5A5A5A5.
- Reset behaviour: hold `rst`=0 for 5 cycles with `start`=1 → all outputs 0, no `rd_en`.
- Basic decode:
  - Stimulus: `file_index`=3; block holds e = {32'h1, 32'h2, 32'h0, 32'h8}, parity correct.
  - Writes: addr 12 ← A5A5A5A4; addr 13 ← 0; addr 14 ← 2; addr 15 ← 1.
  - `finish` rises at cycle 13.
- Busy behaviour: `start` pulsed with `file_index`=5 at cycle 4 of a `file_index`=3 run → only addresses 12..15 written; `finish` at cycle 13.
- Back-to-back blocks: loop `file_index` 0..7, `start` held 3 cycles each, wait on `finish` → 32 writes, each block's output matches the reference model, `finish` drops on each new start.
- Reset mid-run: `rst`=0 at cycle 6 → no `wr_en` after cycle 6; `finish`=0; next `start` decodes correctly from word 0.
- Parity check (macro on): flip parity bit of word 2 → `parity_err`=1 from cycle 9 through DONE; written data unchanged; cleared at next `start`.
